snake_body_tracker: RTL and testbench
=====================================

Name: snake_body_tracker

Overview:
- Tracks the snake's trailing body segments behind the head, in the VGA_clk domain.
- Sits downstream of the head-position mover and upstream of the pixel colour mux.
- Keeps a shift-register history of past head positions, grows on apple-eat, and emits a per-pixel body hit aligned with the existing head hit.
- Also flags self-collision for the game-over logic.

Parameters:
- MAX_SEG, 16, maximum number of body segments (array depth).
- INIT_LEN, 3, body length after reset (1..MAX_SEG).
- SEG_SIZE, 10, segment square edge in pixels (same window as head).
- STEP, 5, pixel distance between reset segment positions (same as per-tick head move).
- INIT_X, 100, head X at reset; segment i resets to INIT_X-(i+1)*STEP.
- INIT_Y, 100, Y of all segments at reset.

Ports:
- VGA_clk  in  1  pixel clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-VGA_clk-cycle pulse per game step, already synchronised upstream.
- head_x  in  10  current head X (pre-move value while tick is high).
- head_y  in  9  current head Y (pre-move value while tick is high).
- grow  in  1  one-cycle pulse, apple eaten.
- x_count  in  10  current pixel X from the VGA generator.
- y_count  in  10  current pixel Y from the VGA generator.
- body_pixel  out  1  registered: current pixel lies inside an active segment.
- self_hit  out  1  sticky: head landed on an active body segment.
- length  out  5  number of active segments.
- full  out  1  length == MAX_SEG.

Behaviour:
- Reset (synchronous, active-high, clock VGA_clk):
  - seg_x[i]=INIT_X-(i+1)*STEP, seg_y[i]=INIT_Y for all i.
  - length=INIT_LEN, grow_pending=0.
  - body_pixel=0, self_hit=0, full=0.
  - Reset mid-game discards all history the same way.
- Grow request:
  - grow sets grow_pending; it stays set until the next tick.
  - Multiple grow pulses between ticks count as one.
- On tick:
  - seg[i]<=seg[i-1] for i=1..MAX_SEG-1; seg[0]<={head_x,head_y}. The sampled value is the pre-move head.
  - If grow_pending, or grow is high in the same cycle, and length<MAX_SEG: length<=length+1.
  - grow_pending clears on every tick.
  - Grow while full is silently dropped; full stays 1.
- Segment activity: segments with index >= length are shifted but inactive. They never contribute to body_pixel or self_hit.
- body_pixel:
  - Registered one cycle after x_count/y_count, matching head latency.
  - =1 iff some active i has x_count > seg_x[i] and x_count < seg_x[i]+SEG_SIZE, and likewise for y.
  - Strict comparisons on both edges.
  - Sums are computed at 11 bits; no wrap at the screen edge.
- self_hit:
  - Evaluated only in the cycle after tick (tick_d), once the mover has applied the new head.
  - Sets if {head_x,head_y} equals {seg_x[i],seg_y[i]} for any active i>=1.
  - Index 0 is excluded, so a stationary head never self-hits.
  - Sticky until reset.
- Simultaneous tick and reset: reset wins.
- length and full are registered and change on the edge after tick.

Decomposition:
- Shared package snake_pkg holds:
  - X_W=10, Y_W=9, SEG_SIZE, STEP, INIT_X, INIT_Y.
  - The direction encoding constants already used by the button block.
- Sub-module seg_hit_cmp: one segment's window compare, inputs (x_count, y_count, seg_x, seg_y, active), output hit.
  - Instantiated MAX_SEG times via generate; results OR-reduced into the body_pixel register.

Test Plan:
- Reset, then scan pixel (96,101) → body_pixel=1 one cycle later (seg0 at 95,100). Pixel (95,101) → 0 (strict edge). length=3.
- Head (105,100), tick → seg0=(105,100), seg1=(95,100), seg2=(90,100). Pixel (86,101) → 0, since seg3 (85,100) is inactive.
- grow pulse, then tick two cycles later → length=4 after tick. Second tick with no grow → length stays 4. Grow and tick in the same cycle → length 5.
- Issue 13 grow+tick pairs from length 3 → length=16, full=1. A further grow+tick leaves length=16.
- Drive segments to a loop, then set head_x/head_y equal to seg2 after a tick → self_hit=1 on the tick_d cycle and stays 1. Head equal to seg0 → self_hit stays 0.
- Assert reset mid-game at length 7 → next cycle length=3, self_hit=0, segments back at reset positions.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants for the snake game datapath.
// Geometry, reset placement and button direction codes.
package snake_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int LEN_W    = 5;
  localparam int SEG_SIZE = 10;
  localparam int STEP     = 5;
  localparam int INIT_X   = 100;
  localparam int INIT_Y   = 100;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

endpackage

// File: rtl/seg_hit_cmp.sv
// Window compare of one body segment against the scanned pixel.
// Strict bounds on both edges; sums at 11 bits so no screen-edge wrap.
module seg_hit_cmp
  import snake_pkg::*;
#(
  parameter int SIZE = snake_pkg::SEG_SIZE
) (
  input  logic [X_W-1:0] x_count,
  input  logic [9:0]     y_count,
  input  logic [X_W-1:0] seg_x,
  input  logic [Y_W-1:0] seg_y,
  input  logic           active,
  output logic           hit
);

  logic [10:0] xc;
  logic [10:0] yc;
  logic [10:0] sx;
  logic [10:0] sy;
  logic        inX;
  logic        inY;

  assign xc = {1'b0, x_count};
  assign yc = {1'b0, y_count};
  assign sx = {1'b0, seg_x};
  assign sy = {2'b00, seg_y};

  assign inX = (xc > sx) && (xc < sx + 11'(SIZE));
  assign inY = (yc > sy) && (yc < sy + 11'(SIZE));
  assign hit = active & inX & inY;

endmodule

// File: rtl/snake_body_tracker.sv
// Head-position history for the snake body, growth on apple-eat,
// per-pixel body hit and sticky self-collision flag.
module snake_body_tracker
  import snake_pkg::*;
#(
  parameter int MAX_SEG  = 16,
  parameter int INIT_LEN = 3,
  parameter int SEG_SIZE = snake_pkg::SEG_SIZE,
  parameter int STEP     = snake_pkg::STEP,
  parameter int INIT_X   = snake_pkg::INIT_X,
  parameter int INIT_Y   = snake_pkg::INIT_Y
) (
  input  logic             VGA_clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [X_W-1:0]   head_x,
  input  logic [Y_W-1:0]   head_y,
  input  logic             grow,
  input  logic [9:0]       x_count,
  input  logic [9:0]       y_count,
  output logic             body_pixel,
  output logic             self_hit,
  output logic [LEN_W-1:0] length,
  output logic             full
);

  logic [X_W-1:0]   seg_x [MAX_SEG];
  logic [Y_W-1:0]   seg_y [MAX_SEG];
  logic             growPending;
  logic             tickD;
  logic             growReq;
  logic [LEN_W-1:0] lenNext;
  logic [MAX_SEG-1:0] active;
  logic [MAX_SEG-1:0] pixHit;
  logic [MAX_SEG-1:0] headHit;

  assign growReq = growPending | grow;

  always_comb begin
    lenNext = length;
    if (growReq && (length < LEN_W'(MAX_SEG)))
      lenNext = length + 1'b1;
  end

  for (genvar i = 0; i < MAX_SEG; i++) begin : g_seg
    assign active[i] = LEN_W'(i) < length;

    seg_hit_cmp #(.SIZE(SEG_SIZE)) u_cmp (
      .x_count (x_count),
      .y_count (y_count),
      .seg_x   (seg_x[i]),
      .seg_y   (seg_y[i]),
      .active  (active[i]),
      .hit     (pixHit[i])
    );

    // seg0 is the pre-move head, so it never counts as a collision
    if (i == 0) begin : g_head
      assign headHit[i] = 1'b0;
    end else begin : g_body
      assign headHit[i] = active[i]
                        && (seg_x[i] == head_x)
                        && (seg_y[i] == head_y);
    end
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_SEG; i++) begin
        seg_x[i] <= X_W'(INIT_X - (i + 1) * STEP);
        seg_y[i] <= Y_W'(INIT_Y);
      end
      length      <= LEN_W'(INIT_LEN);
      full        <= (INIT_LEN == MAX_SEG);
      growPending <= 1'b0;
      tickD       <= 1'b0;
      body_pixel  <= 1'b0;
      self_hit    <= 1'b0;
    end else begin
      tickD      <= tick;
      body_pixel <= |pixHit;
      if (tick) begin
        for (int i = 1; i < MAX_SEG; i++) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0]    <= head_x;
        seg_y[0]    <= head_y;
        length      <= lenNext;
        full        <= (lenNext == LEN_W'(MAX_SEG));
        growPending <= 1'b0;
      end else if (grow) begin
        growPending <= 1'b1;
      end
      if (tickD && (|headHit))
        self_hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker.
// Expected values are hand-derived from segment positions.
module tb_snake_body_tracker;

  logic       VGA_clk;
  logic       reset;
  logic       tick;
  logic [9:0] head_x;
  logic [8:0] head_y;
  logic       grow;
  logic [9:0] x_count;
  logic [9:0] y_count;
  logic       body_pixel;
  logic       self_hit;
  logic [4:0] length;
  logic       full;

  int nCmp = 0;
  int nBad = 0;

  snake_body_tracker dut (
    .VGA_clk    (VGA_clk),
    .reset      (reset),
    .tick       (tick),
    .head_x     (head_x),
    .head_y     (head_y),
    .grow       (grow),
    .x_count    (x_count),
    .y_count    (y_count),
    .body_pixel (body_pixel),
    .self_hit   (self_hit),
    .length     (length),
    .full       (full)
  );

  initial VGA_clk = 1'b0;
  always #5 VGA_clk = ~VGA_clk;

  task automatic step();
    @(posedge VGA_clk);
    @(negedge VGA_clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic setPix(input logic [9:0] x, input logic [9:0] y);
    x_count = x;
    y_count = y;
    step();
  endtask

  // tick with pre-move head, then present the moved head for tick_d
  task automatic doTick(input logic [9:0] hx, input logic [8:0] hy,
                        input logic g,
                        input logic [9:0] nx, input logic [8:0] ny);
    head_x = hx;
    head_y = hy;
    grow   = g;
    tick   = 1'b1;
    step();
    tick   = 1'b0;
    grow   = 1'b0;
    head_x = nx;
    head_y = ny;
    step();
  endtask

  task automatic test_reset();
    x_count = 10'd96;
    y_count = 10'd101;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    nCmp++; if (body_pixel !== 1'b0) begin nBad++; $display("FAIL rst_body_pixel got=%b exp=0", body_pixel); end
    nCmp++; if (length !== 5'd3) begin nBad++; $display("FAIL rst_length got=%0d exp=3", length); end
    nCmp++; if (full !== 1'b0) begin nBad++; $display("FAIL rst_full got=%b exp=0", full); end
    nCmp++; if (self_hit !== 1'b0) begin nBad++; $display("FAIL rst_self_hit got=%b exp=0", self_hit); end
    setPix(10'd96, 10'd101);
    nCmp++; if (body_pixel !== 1'b1) begin nBad++; $display("FAIL rst_pix_96_101 got=%b exp=1", body_pixel); end
    setPix(10'd104, 10'd101);
    nCmp++; if (body_pixel !== 1'b1) begin nBad++; $display("FAIL rst_pix_104_101 got=%b exp=1", body_pixel); end
    setPix(10'd105, 10'd101);
    nCmp++; if (body_pixel !== 1'b0) begin nBad++; $display("FAIL rst_pix_105_101 got=%b exp=0", body_pixel); end
    setPix(10'd86, 10'd101);
    nCmp++; if (body_pixel !== 1'b1) begin nBad++; $display("FAIL rst_pix_86_101 got=%b exp=1", body_pixel); end
    setPix(10'd85, 10'd101);
    nCmp++; if (body_pixel !== 1'b0) begin nBad++; $display("FAIL rst_pix_85_101 got=%b exp=0", body_pixel); end
    setPix(10'd96, 10'd100);
    nCmp++; if (body_pixel !== 1'b0) begin nBad++; $display("FAIL rst_pix_96_100 got=%b exp=0", body_pixel); end
    setPix(10'd96, 10'd110);
    nCmp++; if (body_pixel !== 1'b0) begin nBad++; $display("FAIL rst_pix_96_110 got=%b exp=0", body_pixel); end
  endtask

  task automatic test_shift();
    doTick(10'd105, 9'd100, 1'b0, 10'd110, 9'd100);
    nCmp++; if (length !== 5'd3) begin nBad++; $display("FAIL shift_length got=%0d exp=3", length); end
    nCmp++; if (self_hit !== 1'b0) begin nBad++; $display("FAIL shift_self_hit got=%b exp=0", self_hit); end
    setPix(10'd106, 10'd101);
    nCmp++; if (body_pixel !== 1'b1) begin nBad++; $display("FAIL shift_pix_106 got=%b exp=1", body_pixel); end
    setPix(10'd105, 10'd101);
    nCmp++; if (body_pixel !== 1'b0) begin nBad++; $display("FAIL shift_pix_105 got=%b exp=0", body_pixel); end
    setPix(10'd115, 10'd101);
    nCmp++; if (body_pixel !== 1'b0) begin nBad++; $display("FAIL shift_pix_115 got=%b exp=0", body_pixel); end
    setPix(10'd91, 10'd101);
    nCmp++; if (body_pixel !== 1'b1) begin nBad++; $display("FAIL shift_pix_91 got=%b exp=1", body_pixel); end
    setPix(10'd86, 10'd101);
    nCmp++; if (body_pixel !== 1'b0) begin nBad++; $display("FAIL shift_pix_86_inactive got=%b exp=0", body_pixel); end
  endtask

  task automatic test_grow();
    grow = 1'b1;
    step();
    grow = 1'b0;
    step();
    nCmp++; if (length !== 5'd3) begin nBad++; $display("FAIL grow_pending_len got=%0d exp=3", length); end
    doTick(10'd110, 9'd100, 1'b0, 10'd115, 9'd100);
    nCmp++; if (length !== 5'd4) begin nBad++; $display("FAIL grow_after_tick got=%0d exp=4", length); end
    doTick(10'd115, 9'd100, 1'b0, 10'd120, 9'd100);
    nCmp++; if (length !== 5'd4) begin nBad++; $display("FAIL grow_no_repeat got=%0d exp=4", length); end
    setPix(10'd96, 10'd101);
    nCmp++; if (body_pixel !== 1'b1) begin nBad++; $display("FAIL grow_pix_seg3 got=%b exp=1", body_pixel); end
    setPix(10'd91, 10'd101);
    nCmp++; if (body_pixel !== 1'b0) begin nBad++; $display("FAIL grow_pix_seg4_inactive got=%b exp=0", body_pixel); end
    doTick(10'd120, 9'd100, 1'b1, 10'd125, 9'd100);
    nCmp++; if (length !== 5'd5) begin nBad++; $display("FAIL grow_same_cycle got=%0d exp=5", length); end
    grow = 1'b1;
    step();
    grow = 1'b0;
    step();
    grow = 1'b1;
    step();
    grow = 1'b0;
    step();
    doTick(10'd125, 9'd100, 1'b0, 10'd130, 9'd100);
    nCmp++; if (length !== 5'd6) begin nBad++; $display("FAIL grow_multi_pulse got=%0d exp=6", length); end
    nCmp++; if (self_hit !== 1'b0) begin nBad++; $display("FAIL grow_self_hit got=%b exp=0", self_hit); end
  endtask

  task automatic test_full();
    doReset();
    for (int k = 0; k < 13; k++) begin
      doTick(10'(100 + 5 * k), 9'd100, 1'b1, 10'(105 + 5 * k), 9'd100);
      if (k == 11) begin
        nCmp++; if (length !== 5'd15) begin nBad++; $display("FAIL full_len15 got=%0d exp=15", length); end
        nCmp++; if (full !== 1'b0) begin nBad++; $display("FAIL full_not_yet got=%b exp=0", full); end
      end
    end
    nCmp++; if (length !== 5'd16) begin nBad++; $display("FAIL full_len16 got=%0d exp=16", length); end
    nCmp++; if (full !== 1'b1) begin nBad++; $display("FAIL full_flag got=%b exp=1", full); end
    doTick(10'd165, 9'd100, 1'b1, 10'd170, 9'd100);
    nCmp++; if (length !== 5'd16) begin nBad++; $display("FAIL full_saturate got=%0d exp=16", length); end
    nCmp++; if (full !== 1'b1) begin nBad++; $display("FAIL full_stays got=%b exp=1", full); end
    nCmp++; if (self_hit !== 1'b0) begin nBad++; $display("FAIL full_self_hit got=%b exp=0", self_hit); end
  endtask

  task automatic test_self_hit();
    doReset();
    doTick(10'd100, 9'd100, 1'b0, 10'd100, 9'd100);
    nCmp++; if (self_hit !== 1'b0) begin nBad++; $display("FAIL hit_seg0_excluded got=%b exp=0", self_hit); end
    doReset();
    doTick(10'd100, 9'd100, 1'b0, 10'd85, 9'd100);
    nCmp++; if (self_hit !== 1'b0) begin nBad++; $display("FAIL hit_inactive got=%b exp=0", self_hit); end
    doReset();
    doTick(10'd100, 9'd100, 1'b1, 10'd100, 9'd105);
    doTick(10'd100, 9'd105, 1'b1, 10'd95, 9'd105);
    nCmp++; if (self_hit !== 1'b0) begin nBad++; $display("FAIL hit_before_loop got=%b exp=0", self_hit); end
    doTick(10'd95, 9'd105, 1'b0, 10'd100, 9'd100);
    nCmp++; if (self_hit !== 1'b1) begin nBad++; $display("FAIL hit_seg2 got=%b exp=1", self_hit); end
    step();
    step();
    doTick(10'd100, 9'd100, 1'b0, 10'd105, 9'd100);
    nCmp++; if (self_hit !== 1'b1) begin nBad++; $display("FAIL hit_sticky got=%b exp=1", self_hit); end
    nCmp++; if (length !== 5'd5) begin nBad++; $display("FAIL hit_length got=%0d exp=5", length); end
  endtask

  task automatic test_mid_reset();
    doTick(10'd105, 9'd100, 1'b1, 10'd110, 9'd100);
    doTick(10'd110, 9'd100, 1'b1, 10'd115, 9'd100);
    nCmp++; if (length !== 5'd7) begin nBad++; $display("FAIL mid_len7 got=%0d exp=7", length); end
    setPix(10'd99, 10'd112);
    nCmp++; if (body_pixel !== 1'b1) begin nBad++; $display("FAIL mid_pix_pre got=%b exp=1", body_pixel); end
    reset  = 1'b1;
    tick   = 1'b1;
    grow   = 1'b1;
    head_x = 10'd200;
    head_y = 9'd200;
    step();
    reset = 1'b0;
    tick  = 1'b0;
    grow  = 1'b0;
    nCmp++; if (length !== 5'd3) begin nBad++; $display("FAIL mid_rst_len got=%0d exp=3", length); end
    nCmp++; if (self_hit !== 1'b0) begin nBad++; $display("FAIL mid_rst_self_hit got=%b exp=0", self_hit); end
    nCmp++; if (full !== 1'b0) begin nBad++; $display("FAIL mid_rst_full got=%b exp=0", full); end
    setPix(10'd99, 10'd112);
    nCmp++; if (body_pixel !== 1'b0) begin nBad++; $display("FAIL mid_pix_99_112 got=%b exp=0", body_pixel); end
    setPix(10'd86, 10'd101);
    nCmp++; if (body_pixel !== 1'b1) begin nBad++; $display("FAIL mid_pix_86_101 got=%b exp=1", body_pixel); end
    setPix(10'd85, 10'd101);
    nCmp++; if (body_pixel !== 1'b0) begin nBad++; $display("FAIL mid_pix_85_101 got=%b exp=0", body_pixel); end
  endtask

  initial begin
    reset   = 1'b0;
    tick    = 1'b0;
    grow    = 1'b0;
    head_x  = 10'd100;
    head_y  = 9'd100;
    x_count = 10'd0;
    y_count = 10'd0;
    @(negedge VGA_clk);
    test_reset();
    test_shift();
    test_grow();
    test_full();
    test_self_hit();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
